// File: rtl/asrv32_pipe_ctrl.sv
// ASRV32 five-stage pipeline sequencer: stage valids, stall chain, enables/flushes and
// the drain-then-redirect exception FSM (built only when ASRV32_TRAP_EN is defined).
module asrv32_pipe_ctrl #(
  parameter int REDIRECT_CYCLES = 1,
  localparam int EXCEPTION_WIDTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_fetch_ack,
  input  logic                       i_load_use,
  input  logic                       i_x_stall,
  input  logic                       i_dmem_stall,
  input  logic                       i_branch_taken,
  input  logic [EXCEPTION_WIDTH-1:0] i_exception,
  output logic [4:0]                 o_ce,
  output logic [4:0]                 o_flush,
  output logic [4:0]                 o_valid,
  output logic                       o_trap_redirect,
  output logic                       o_mret_redirect,
  output logic [EXCEPTION_WIDTH-1:0] o_trap_cause,
  output logic [1:0]                 o_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Exception bit order: [0] ILLEGAL, [1] ECALL, [2] EBREAK, [3] MRET
  localparam logic [EXCEPTION_WIDTH-1:0] MRET_ONLY = EXCEPTION_WIDTH'(8);

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [EXCEPTION_WIDTH-1:0] cause_q, cause_d;
  logic                       dec_vld_q, dec_vld_d;
  logic                       exe_vld_q, exe_vld_d;
  logic                       mem_vld_q, mem_vld_d;
  logic                       wb_vld_q, wb_vld_d;

  logic       st_m, st_x, st_d, lu, br, exc, exc_raw;
  logic [4:0] ce, flush;
  logic       redirect_active, mret_only;

  assign st_m = i_dmem_stall;
  assign st_x = i_x_stall | st_m;
  assign lu   = i_load_use & dec_vld_q;
  assign st_d = lu | st_x;
  assign br   = (state_q == ST_RUN) & exe_vld_q & ~st_x & i_branch_taken;
  assign exc  = (state_q == ST_RUN) & exe_vld_q & ~st_x & exc_raw;

  assign redirect_active = (state_q == ST_REDIRECT);
  assign mret_only       = (cause_q == MRET_ONLY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    ce        = {1'b1, ~st_m, 3'b000};
    flush     = 5'b00000;
    wb_vld_d  = mem_vld_q & ~st_m;
    mem_vld_d = mem_vld_q;
    exe_vld_d = exe_vld_q;
    dec_vld_d = dec_vld_q;

    unique case (state_q)
      ST_RUN: begin
        ce[2]    = ~st_x;
        ce[1]    = ~st_d | br | exc;
        ce[0]    = (~st_d & i_fetch_ack) | br;
        flush[1] = br | exc;
        flush[2] = exc;
        if (!st_m) mem_vld_d = exe_vld_q & ~st_x & ~exc;
        if (!st_x) exe_vld_d = dec_vld_q & ~lu & ~br & ~exc;
        if (br | exc) dec_vld_d = 1'b0;
        else if (!st_d) dec_vld_d = i_fetch_ack;
        if (exc) begin
          state_d = ST_DRAIN;
          cause_d = i_exception;
        end
      end
      ST_DRAIN: begin
        dec_vld_d = 1'b0;
        exe_vld_d = 1'b0;
        if (!st_m) mem_vld_d = 1'b0;
        // A memory stall freezes the drain, so every stalled cycle adds exactly one cycle
        if (st_m) wb_vld_d = wb_vld_q;
        if (!mem_vld_q && !wb_vld_q && !st_m) begin
          state_d = ST_REDIRECT;
          cnt_d   = 4'(REDIRECT_CYCLES - 1);
        end
      end
      ST_REDIRECT: begin
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

`ifdef ASRV32_TRAP_EN
  assign exc_raw         = |i_exception;
  assign o_trap_cause    = cause_q;
  assign o_trap_redirect = redirect_active & ~mret_only;
  assign o_mret_redirect = redirect_active & mret_only;
`else
  assign exc_raw         = 1'b0;
  assign o_trap_cause    = '0;
  assign o_trap_redirect = 1'b0;
  assign o_mret_redirect = 1'b0;
  logic unused_trap;
  assign unused_trap = ^{redirect_active, mret_only};
`endif

  // Reset forces the PC and W enables on and everything else quiet
  always_comb begin
    if (!i_rst_n) begin
      o_ce    = 5'b10001;
      o_flush = 5'b00000;
    end else begin
      o_ce    = ce;
      o_flush = flush;
    end
  end

  assign o_valid = {wb_vld_q, mem_vld_q, exe_vld_q, dec_vld_q, i_fetch_ack & i_rst_n};
  assign o_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= 4'd0;
      cause_q   <= '0;
      dec_vld_q <= 1'b0;
      exe_vld_q <= 1'b0;
      mem_vld_q <= 1'b0;
      wb_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      dec_vld_q <= dec_vld_d;
      exe_vld_q <= exe_vld_d;
      mem_vld_q <= mem_vld_d;
      wb_vld_q  <= wb_vld_d;
    end
  end

endmodule
